// File: rtl/ods_pkg.sv
// Shared types and constants for the output data shifter sequencer.
package ods_pkg;

  localparam int unsigned CNT_W     = 16;
  localparam int unsigned NUM_LANES = 3;
  localparam int unsigned LANE_W    = 2;

  localparam logic [LANE_W-1:0] SEL_IDLE = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } ods_state_t;

endpackage

// File: rtl/ods_if.sv
// Control/handshake bundle between the ODS sequencer and its producer/consumer.
interface ods_if;
  import ods_pkg::*;

  logic              start;
  logic [CNT_W-1:0]  cfg_num_triples;
  logic              in_valid;
  logic              in_ready;
  logic [LANE_W-1:0] sel_out;
  logic              shift;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic              busy;
  logic              done;

  // Producer/consumer side
  modport master (
    output start, cfg_num_triples, in_valid, out_ready,
    input  in_ready, sel_out, shift, out_valid, out_last, busy, done
  );

  // Sequencer side
  modport slave (
    input  start, cfg_num_triples, in_valid, out_ready,
    output in_ready, sel_out, shift, out_valid, out_last, busy, done
  );

endinterface

// File: rtl/ods_ctrl.sv
// Sequencer for the 3-lane, 2-stage output data shifter: steers words into
// lanes, moves full triples to the output stage and counts triples per frame.
module ods_ctrl
  import ods_pkg::*;
(
  input  logic  clk,
  input  logic  arst_n_in,
  ods_if.slave  bus
);

  ods_state_t        state, state_nxt;
  logic [LANE_W-1:0] lane_cnt, lane_nxt;
  logic              s1_full, s1_nxt;
  logic              s2_full, s2_nxt;
  logic [CNT_W-1:0]  num_triples, num_nxt;
  logic [CNT_W-1:0]  acc_cnt, acc_nxt;
  logic [CNT_W-1:0]  emit_cnt, emit_nxt;

  logic              take;
  logic              shift_c;
  logic              in_ready_c;
  logic              wr;
  logic              lane_last;
  logic              last_trip;
  logic [LANE_W-1:0] sel_c;

  // State register; a synchronous reset drops any frame in flight
  always_ff @(posedge clk) begin
    if (!arst_n_in) begin
      state       <= IDLE;
      lane_cnt    <= '0;
      s1_full     <= 1'b0;
      s2_full     <= 1'b0;
      num_triples <= '0;
      acc_cnt     <= '0;
      emit_cnt    <= '0;
    end else begin
      state       <= state_nxt;
      lane_cnt    <= lane_nxt;
      s1_full     <= s1_nxt;
      s2_full     <= s2_nxt;
      num_triples <= num_nxt;
      acc_cnt     <= acc_nxt;
      emit_cnt    <= emit_nxt;
    end
  end

  // Handshake decode, stage occupancy tracking and frame sequencing
  always_comb begin
    state_nxt = state;
    lane_nxt  = lane_cnt;
    s1_nxt    = s1_full;
    s2_nxt    = s2_full;
    num_nxt   = num_triples;
    acc_nxt   = acc_cnt;
    emit_nxt  = emit_cnt;

    take       = s2_full & bus.out_ready;
    last_trip  = (emit_cnt == num_triples - CNT_W'(1));
    shift_c    = s1_full & (~s2_full | take);
    in_ready_c = (state == RUN) & (~s1_full | shift_c);
    wr         = bus.in_valid & in_ready_c;
    lane_last  = (lane_cnt == LANE_W'(NUM_LANES - 1));
    sel_c      = wr ? lane_cnt : SEL_IDLE;

    // Lane pointer and stage-1 fill; a write to lane 0 may share the edge with a shift
    if (wr) begin
      lane_nxt = lane_last ? '0 : lane_cnt + LANE_W'(1);
    end
    if (wr && lane_last) begin
      s1_nxt  = 1'b1;
      acc_nxt = acc_cnt + CNT_W'(1);
    end else if (shift_c) begin
      s1_nxt = 1'b0;
    end

    // Stage 2 stays full when a take and a refill coincide
    if (shift_c) begin
      s2_nxt = 1'b1;
    end else if (take) begin
      s2_nxt = 1'b0;
    end
    if (take) begin
      emit_nxt = emit_cnt + CNT_W'(1);
    end

    case (state)
      IDLE: begin
        if (bus.start) begin
          num_nxt   = bus.cfg_num_triples;
          lane_nxt  = '0;
          s1_nxt    = 1'b0;
          s2_nxt    = 1'b0;
          acc_nxt   = '0;
          emit_nxt  = '0;
          state_nxt = (bus.cfg_num_triples == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (wr && lane_last && (acc_cnt == num_triples - CNT_W'(1))) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (take && last_trip) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.sel_out   = sel_c;
  assign bus.shift     = shift_c;
  assign bus.out_valid = s2_full;
  assign bus.out_last  = s2_full & last_trip;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == DONE);

endmodule
